// File: rtl/hammu_seq_if.sv
// hammu_seq_if: request/response stream and AXI4-Lite master bus of the
// exponent-core sequencer. The "master" modport is the sequencer's view,
// the "slave" modport is the view of whatever surrounds it (producer,
// consumer and the exponent core's AXI4-Lite slave).
interface hammu_seq_if;
  // request stream
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x;
  // response stream
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_err;
  logic        busy;
  // AXI4-Lite write address / data / response
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  // AXI4-Lite read address / data
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    input  req_valid, req_x, rsp_ready,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output req_ready, rsp_valid, rsp_y, rsp_err, busy,
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );

  modport slave (
    output req_valid, req_x, rsp_ready,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  req_ready, rsp_valid, rsp_y, rsp_err, busy,
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );
endinterface

// File: rtl/hammu_seq.sv
// hammu_seq: AXI4-Lite master sequencer for the exponent core.
// Takes one operand, writes X, writes CTRL.start, polls STATUS.done,
// reads RESULT and returns it (or an error) on the response stream.
// Optional feature macro: HAMMU_SEQ_POLL_TIMEOUT_EN bounds STATUS polling
// to C_POLL_MAX reads and reports a timeout as an error.
//
// Handshakes (request, response and every AXI channel): a transfer happens
// on a rising clock edge where VALID and READY are both high. Once raised,
// a VALID stays high with a stable payload until that edge; READY may be
// raised or dropped at any time.
module hammu_seq #(
  parameter logic [31:0] C_BASEADDR = 32'h70e00000,
  parameter int unsigned C_POLL_MAX = 1023,
  parameter int unsigned C_POLL_GAP = 0
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  hammu_seq_if.master bus,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] ADDR_X      = C_BASEADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL   = C_BASEADDR + 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS = C_BASEADDR + 32'h0000_0008;
  localparam logic [31:0] ADDR_RESULT = C_BASEADDR + 32'h0000_000C;
  localparam logic [7:0]  GAP_LAST    = (C_POLL_GAP > 0) ? 8'(C_POLL_GAP - 1) : 8'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_X   = 3'd1,
    WR_GO  = 3'd2,
    RD_ST  = 3'd3,
    GAP    = 3'd4,
    RD_RES = 3'd5,
    RSP    = 3'd6
  } state_t;

  state_t     state;
  logic [7:0] gap_cnt;
  logic       accept;
  logic       poll_timeout;

  assign accept           = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign dbg_state        = state;
  assign bus.M_AXI_WSTRB  = 4'hF;

`ifdef HAMMU_SEQ_POLL_TIMEOUT_EN
  localparam logic [16:0] POLL_LIMIT = 17'(C_POLL_MAX);

  logic [15:0] poll_cnt;
  logic        poll_miss;
  logic [16:0] poll_next;

  // a STATUS read completing cleanly with done still low
  assign poll_miss = (state == RD_ST) && !bus.M_AXI_ARVALID && bus.M_AXI_RREADY &&
                     bus.M_AXI_RVALID && (bus.M_AXI_RRESP == 2'b00) && !bus.M_AXI_RDATA[0];
  assign poll_next    = {1'b0, poll_cnt} + 17'd1;
  assign poll_timeout = poll_miss && (poll_next >= POLL_LIMIT);

  // count not-done STATUS reads of the current request
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      poll_cnt <= 16'd0;
    end else if (accept) begin
      poll_cnt <= 16'd0;
    end else if (poll_miss) begin
      poll_cnt <= poll_next[15:0];
    end
  end
`else
  assign poll_timeout = 1'b0;

  // C_POLL_MAX has no effect while polling is unbounded
  if (C_POLL_MAX == 0) begin : g_poll_max_inert
  end
`endif

  // sequencer FSM; every output is a register written only here
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state             <= IDLE;
      gap_cnt           <= 8'd0;
      bus.req_ready     <= 1'b0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_y         <= 32'd0;
      bus.rsp_err       <= 1'b0;
      bus.busy          <= 1'b0;
      bus.M_AXI_AWADDR  <= 32'd0;
      bus.M_AXI_AWVALID <= 1'b0;
      bus.M_AXI_WDATA   <= 32'd0;
      bus.M_AXI_WVALID  <= 1'b0;
      bus.M_AXI_BREADY  <= 1'b0;
      bus.M_AXI_ARADDR  <= 32'd0;
      bus.M_AXI_ARVALID <= 1'b0;
      bus.M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready     <= 1'b0;
            bus.busy          <= 1'b1;
            bus.rsp_err       <= 1'b0;
            bus.M_AXI_AWADDR  <= ADDR_X;
            bus.M_AXI_WDATA   <= bus.req_x;
            bus.M_AXI_AWVALID <= 1'b1;
            bus.M_AXI_WVALID  <= 1'b1;
            state             <= WR_X;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        WR_X, WR_GO: begin
          if (!bus.M_AXI_BREADY) begin
            // address and data are accepted independently, in any order
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) bus.M_AXI_AWVALID <= 1'b0;
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY)   bus.M_AXI_WVALID  <= 1'b0;
            if ((!bus.M_AXI_AWVALID || bus.M_AXI_AWREADY) &&
                (!bus.M_AXI_WVALID  || bus.M_AXI_WREADY)) begin
              bus.M_AXI_BREADY <= 1'b1;
            end
          end else if (bus.M_AXI_BVALID) begin
            bus.M_AXI_BREADY <= 1'b0;
            if (bus.M_AXI_BRESP != 2'b00) begin
              bus.rsp_err <= 1'b1;
              bus.rsp_y   <= 32'd0;
              state       <= RSP;
            end else if (state == WR_X) begin
              bus.M_AXI_AWADDR  <= ADDR_CTRL;
              bus.M_AXI_WDATA   <= 32'h0000_0001;
              bus.M_AXI_AWVALID <= 1'b1;
              bus.M_AXI_WVALID  <= 1'b1;
              state             <= WR_GO;
            end else begin
              bus.M_AXI_ARADDR  <= ADDR_STATUS;
              bus.M_AXI_ARVALID <= 1'b1;
              state             <= RD_ST;
            end
          end
        end

        RD_ST, RD_RES: begin
          if (bus.M_AXI_ARVALID) begin
            if (bus.M_AXI_ARREADY) begin
              bus.M_AXI_ARVALID <= 1'b0;
              bus.M_AXI_RREADY  <= 1'b1;
            end
          end else if (bus.M_AXI_RREADY && bus.M_AXI_RVALID) begin
            bus.M_AXI_RREADY <= 1'b0;
            if (bus.M_AXI_RRESP != 2'b00) begin
              bus.rsp_err <= 1'b1;
              bus.rsp_y   <= 32'd0;
              state       <= RSP;
            end else if (state == RD_RES) begin
              bus.rsp_y <= bus.M_AXI_RDATA;
              state     <= RSP;
            end else if (bus.M_AXI_RDATA[0]) begin
              bus.M_AXI_ARADDR  <= ADDR_RESULT;
              bus.M_AXI_ARVALID <= 1'b1;
              state             <= RD_RES;
            end else if (poll_timeout) begin
              bus.rsp_err <= 1'b1;
              bus.rsp_y   <= 32'd0;
              state       <= RSP;
            end else if (C_POLL_GAP > 0) begin
              gap_cnt <= 8'd0;
              state   <= GAP;
            end else begin
              bus.M_AXI_ARVALID <= 1'b1;
              state             <= RD_ST;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus.M_AXI_ARVALID <= 1'b1;
            state             <= RD_ST;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        RSP: begin
          // rsp_valid rises one cycle after entry, then holds until taken
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hammu_seq.sv
// tb_hammu_seq: directed bench for hammu_seq with a behavioural AXI4-Lite
// exponent-core slave (configurable READY delays, BRESP error, done-after-N).
module tb_hammu_seq;

  localparam logic [31:0] BASE   = 32'h70e00000;
  localparam logic [31:0] A_X    = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_ST   = BASE + 32'h8;
  localparam logic [31:0] A_RES  = BASE + 32'hC;
  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_RDST = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hammu_seq_if bus ();
  logic [2:0] dbg_state;

  hammu_seq #(
    .C_BASEADDR(BASE),
    .C_POLL_MAX(5),
    .C_POLL_GAP(2)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic        bresp_err_ctrl = 1'b0;
  int          done_at = 1;
  logic [31:0] result_val = 32'd0;

  int cyc = 0;
  int st_reads = 0;
  int res_reads = 0;
  int aw_hs_cnt = 0;
  int ar_hs_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          st_stamp_q[$];

  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  int          aw_wait, w_wait;

  assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_wait >= aw_delay);
  assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_wait >= w_delay);
  assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    logic aw_hs, w_hs, aw_have, w_have;
    logic [31:0] a, d;
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
      aw_addr_l <= 32'd0; w_data_l <= 32'd0;
      bus.M_AXI_BVALID <= 1'b0; bus.M_AXI_BRESP <= 2'b00;
      bus.M_AXI_RVALID <= 1'b0; bus.M_AXI_RRESP <= 2'b00; bus.M_AXI_RDATA <= 32'd0;
    end else begin
      aw_hs   = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      w_hs    = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      aw_have = aw_got || aw_hs;
      w_have  = w_got || w_hs;
      a = aw_hs ? bus.M_AXI_AWADDR : aw_addr_l;
      d = w_hs ? bus.M_AXI_WDATA : w_data_l;
      if (aw_hs) begin aw_wait <= 0; aw_hs_cnt <= aw_hs_cnt + 1; end
      else if (bus.M_AXI_AWVALID) aw_wait <= aw_wait + 1;
      if (w_hs) w_wait <= 0;
      else if (bus.M_AXI_WVALID) w_wait <= w_wait + 1;
      if (aw_have && w_have && !bus.M_AXI_BVALID) begin
        bus.M_AXI_BVALID <= 1'b1;
        bus.M_AXI_BRESP  <= (bresp_err_ctrl && a == A_CTRL) ? 2'b10 : 2'b00;
        wr_addr_q.push_back(a);
        wr_data_q.push_back(d);
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= bus.M_AXI_AWADDR; end
        if (w_hs)  begin w_got <= 1'b1;  w_data_l <= bus.M_AXI_WDATA; end
        if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 1'b0;
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        ar_hs_cnt <= ar_hs_cnt + 1;
        bus.M_AXI_RVALID <= 1'b1;
        bus.M_AXI_RRESP  <= 2'b00;
        if (bus.M_AXI_ARADDR == A_ST) begin
          st_reads <= st_reads + 1;
          st_stamp_q.push_back(cyc);
          bus.M_AXI_RDATA <= (st_reads + 1 >= done_at) ? 32'h0000_0001 : 32'hFFFF_FFFE;
        end else if (bus.M_AXI_ARADDR == A_RES) begin
          res_reads <= res_reads + 1;
          bus.M_AXI_RDATA <= result_val;
        end else begin
          bus.M_AXI_RDATA <= 32'hDEAD_BEEF;
        end
      end else if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
        bus.M_AXI_RVALID <= 1'b0;
      end
    end
  end

  // ---------------- protocol hold checks and scoreboard ----------------
  logic        p_aw_pend = 1'b0, p_w_pend = 1'b0, p_ar_pend = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      if (p_aw_pend) chk("aw_hold", {bus.M_AXI_AWVALID, bus.M_AXI_AWADDR}, {1'b1, p_awaddr});
      if (p_w_pend)  chk("w_hold",  {bus.M_AXI_WVALID, bus.M_AXI_WDATA},   {1'b1, p_wdata});
      if (p_ar_pend) chk("ar_hold", {bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}, {1'b1, p_araddr});
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_err_y", {bus.rsp_err, bus.rsp_y}, e);
        end
      end
    end
    p_aw_pend = rst_n && bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
    p_w_pend  = rst_n && bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
    p_ar_pend = rst_n && bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
    p_awaddr  = bus.M_AXI_AWADDR;
    p_wdata   = bus.M_AXI_WDATA;
    p_araddr  = bus.M_AXI_ARADDR;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_y"}, bus.rsp_y, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_valids"}, {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}, 0);
    chk({tag, "_readys"}, {bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 0);
    chk({tag, "_awaddr"}, bus.M_AXI_AWADDR, 0);
    chk({tag, "_araddr"}, bus.M_AXI_ARADDR, 0);
    chk({tag, "_wdata"}, bus.M_AXI_WDATA, 0);
    chk({tag, "_wstrb"}, bus.M_AXI_WSTRB, 4'hF);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  task automatic send(input logic [31:0] x, input logic [32:0] e);
    int n = 0;
    while (!bus.req_ready && n < 100) begin tick(); n++; end
    chk("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_x     = x;
    exp_q.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("req_ready_after_accept", bus.req_ready, 0);
  endtask

  task automatic wait_rsp(input int max, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < max) begin tick(); lat++; end
    chk("rsp_wait", bus.rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("req_ready_after_rsp", bus.req_ready, 1);
    chk("rsp_valid_after_rsp", bus.rsp_valid, 0);
    chk("busy_after_rsp", bus.busy, 0);
  endtask

  task automatic check_writes(input string tag, input int base_idx, input logic [31:0] x);
    chk({tag, "_nwr"}, wr_addr_q.size() - base_idx, 2);
    if (wr_addr_q.size() >= base_idx + 2) begin
      chk({tag, "_wr_x_addr"}, wr_addr_q[base_idx], A_X);
      chk({tag, "_wr_x_data"}, wr_data_q[base_idx], x);
      chk({tag, "_wr_ctrl_addr"}, wr_addr_q[base_idx + 1], A_CTRL);
      chk({tag, "_wr_ctrl_data"}, wr_data_q[base_idx + 1], 32'h1);
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, n, wr0, st0, res0, ar0, aw0, s0;
    logic [31:0] x, y;

    bus.req_valid = 1'b0;
    bus.req_x     = 32'd0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    chk("req_ready_first_cycle", bus.req_ready, 1);
    chk("busy_idle", bus.busy, 0);

    // 1: zero-wait slave, done on first poll
    result_val = 32'h402DF854;
    done_at = st_reads + 1;
    wr0 = wr_addr_q.size(); st0 = st_reads;
    send(32'h3F800000, {1'b0, 32'h402DF854});
    wait_rsp(200, lat);
    chk("t1_latency", lat, 9);
    finish_rsp();
    check_writes("t1", wr0, 32'h3F800000);
    chk("t1_status_reads", st_reads - st0, 1);

    // 2: WREADY 3 cycles ahead of AWREADY, done on 4th poll, 2-cycle gaps
    aw_delay = 3; w_delay = 0;
    x = $urandom; y = $urandom;
    result_val = y;
    done_at = st_reads + 4;
    wr0 = wr_addr_q.size(); st0 = st_reads; res0 = res_reads; s0 = st_stamp_q.size();
    send(x, {1'b0, y});
    wait_rsp(300, lat);
    chk("t2_latency", lat, 27);
    finish_rsp();
    check_writes("t2", wr0, x);
    chk("t2_status_reads", st_reads - st0, 4);
    chk("t2_result_reads", res_reads - res0, 1);
    if (st_stamp_q.size() >= s0 + 4)
      for (int i = 1; i < 4; i++)
        chk("t2_poll_interval", st_stamp_q[s0 + i] - st_stamp_q[s0 + i - 1], 4);
    aw_delay = 0;

    // 3: error response on the CTRL write
    bresp_err_ctrl = 1'b1;
    x = $urandom;
    wr0 = wr_addr_q.size(); ar0 = ar_hs_cnt;
    send(x, {1'b1, 32'h0});
    wait_rsp(200, lat);
    finish_rsp();
    check_writes("t3", wr0, x);
    chk("t3_no_reads", ar_hs_cnt - ar0, 0);
    bresp_err_ctrl = 1'b0;

    // 4: polling bound
`ifdef HAMMU_SEQ_POLL_TIMEOUT_EN
    done_at = st_reads + 1000;
    st0 = st_reads; res0 = res_reads;
    send($urandom, {1'b1, 32'h0});
    wait_rsp(500, lat);
    chk("t4_latency", lat, 23);
    finish_rsp();
    chk("t4_status_reads", st_reads - st0, 5);
    chk("t4_result_reads", res_reads - res0, 0);
`else
    y = $urandom;
    result_val = y;
    done_at = st_reads + 50;
    st0 = st_reads;
    send($urandom, {1'b0, y});
    wait_rsp(1000, lat);
    chk("t4_latency", lat, 205);
    finish_rsp();
    chk("t4_status_reads", st_reads - st0, 50);
`endif

    // 5: consumer stalls for 10 cycles; W accepted after AW this time
    w_delay = 2;
    y = $urandom;
    result_val = y;
    done_at = st_reads + 1;
    send($urandom, {1'b0, y});
    wait_rsp(200, lat);
    chk("t5_latency", lat, 13);
    aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_valid", bus.rsp_valid, 1);
      chk("t5_hold_y", {bus.rsp_err, bus.rsp_y}, {1'b0, y});
      chk("t5_hold_req_ready", bus.req_ready, 0);
      chk("t5_hold_no_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}, 0);
    end
    chk("t5_no_aw", aw_hs_cnt - aw0, 0);
    chk("t5_no_ar", ar_hs_cnt - ar0, 0);
    finish_rsp();
    w_delay = 0;

    // 6: reset while a STATUS read address is outstanding
    done_at = st_reads + 1000;
    send($urandom, {1'b0, 32'h0});
    n = 0;
    while (!(bus.M_AXI_ARVALID && dbg_state == S_RDST) && n < 100) begin tick(); n++; end
    chk("t6_arvalid_in_rd_st", bus.M_AXI_ARVALID, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_req_ready_after_reset", bus.req_ready, 1);
    y = $urandom;
    x = $urandom;
    result_val = y;
    done_at = st_reads + 1;
    wr0 = wr_addr_q.size();
    send(x, {1'b0, y});
    wait_rsp(200, lat);
    chk("t6_latency", lat, 9);
    finish_rsp();
    check_writes("t6", wr0, x);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
